// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter for a shared register memory
module mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              mode0,
  input  logic              mode1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_mode,
  input  logic [DATA_W-1:0] mem_dataout
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t              state_q, state_d;
  // Id of the requester served last; 1 after reset so requester 0 wins a tie.
  logic                last_q, last_d;
  logic                id_q, id_d;
  logic                we_q, we_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                win;

  // State, pointer, latched request fields and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      mode_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      we_q     <= we_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next-state, arbitration and per-state outputs.
  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    id_d             = id_q;
    we_d             = we_q;
    mode_d           = mode_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    rdata0_d         = rdata0_q;
    rdata1_d         = rdata1_q;
    win              = 1'b0;
    gnt0             = 1'b0;
    gnt1             = 1'b0;
    done0            = 1'b0;
    done1            = 1'b0;
    mem_write_enable = 1'b0;
    mem_datain       = '0;
    mem_mode         = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // A tie goes to whoever was not served last; a lone request always wins.
          win     = (req0 && req1) ? ~last_q : req1;
          state_d = ISSUE;
          last_d  = win;
          id_d    = win;
          we_d    = win ? we1 : we0;
          mode_d  = win ? mode1 : mode0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
        end
      end
      ISSUE: begin
        gnt0             = ~id_q;
        gnt1             = id_q;
        mem_write_enable = we_q;
        mem_datain       = wdata_q;
        mem_mode         = we_q & mode_q;
        state_d          = DONE;
      end
      DONE: begin
        done0 = ~id_q;
        done1 = id_q;
        if (id_q) begin
          rdata1_d = mem_dataout;
        end else begin
          rdata0_d = mem_dataout;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign mem_addr = addr_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, mode0, mode1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [31:0] rdata0, rdata1;
  logic        mem_write_enable, mem_mode;
  logic [4:0]  mem_addr;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory seen by the arbiter and the reference copy used for prediction.
  logic [31:0] mem_cells [32];
  logic [31:0] ref_mem   [32];
  int          ref_last;
  logic [31:0] exp_rd0, exp_rd1;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .mode0(mode0), .mode1(mode1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .mem_datain(mem_datain), .mem_mode(mem_mode), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  // Registered memory: one-cycle read latency, swap returns the old contents.
  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem_dataout <= mem_mode ? mem_cells[mem_addr] : mem_datain;
      mem_cells[mem_addr] <= mem_datain;
    end else begin
      mem_dataout <= mem_cells[mem_addr];
    end
  end

  // Gnt and done pairs are mutually exclusive on every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
      check("done_excl", 32'(done0 & done1), 32'd0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_inputs();
    req0   = 1'($urandom);
    req1   = 1'($urandom);
    we0    = 1'($urandom);
    we1    = 1'($urandom);
    mode0  = 1'($urandom);
    mode1  = 1'($urandom);
    addr0  = 5'($urandom);
    addr1  = 5'($urandom);
    wdata0 = $urandom;
    wdata1 = $urandom;
  endtask

  // Called just after a rising edge with the arbiter idle; returns just after
  // the rising edge at which it is idle again.
  task automatic do_slot(input bit r0, input bit r1, input bit w0, input bit w1,
                         input bit m0, input bit m1, input logic [4:0] a0,
                         input logic [4:0] a1, input logic [31:0] d0,
                         input logic [31:0] d1, input bit junk);
    int          w;
    bit          t_we, t_md;
    logic [4:0]  t_a;
    logic [31:0] t_d, t_exp;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1; mode0 = m0; mode1 = m1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("idle_mem_we", 32'(mem_write_enable), 32'd0);
    check("idle_datain", mem_datain, 32'd0);
    check("rdata0", rdata0, exp_rd0);
    check("rdata1", rdata1, exp_rd1);
    @(posedge clk); #1;
    if (!(r0 || r1)) return;
    w = (r0 && r1) ? (1 - ref_last) : (r1 ? 1 : 0);
    ref_last = w;
    t_we = w ? w1 : w0;
    t_md = w ? m1 : m0;
    t_a  = w ? a1 : a0;
    t_d  = w ? d1 : d0;
    if (t_we) begin
      t_exp = t_md ? ref_mem[t_a] : t_d;
      ref_mem[t_a] = t_d;
    end else begin
      t_exp = ref_mem[t_a];
    end
    if (junk) scramble_inputs();
    @(negedge clk);
    check("issue_gnt0", 32'(gnt0), 32'(w == 0));
    check("issue_gnt1", 32'(gnt1), 32'(w == 1));
    check("issue_busy", 32'(busy), 32'd1);
    check("issue_done", 32'({done0, done1}), 32'd0);
    check("issue_mem_we", 32'(mem_write_enable), 32'(t_we));
    check("issue_mem_addr", 32'(mem_addr), 32'(t_a));
    check("issue_mem_datain", mem_datain, t_d);
    check("issue_mem_mode", 32'(mem_mode), 32'(t_we & t_md));
    @(posedge clk); #1;
    if (junk) scramble_inputs();
    @(negedge clk);
    check("done_done0", 32'(done0), 32'(w == 0));
    check("done_done1", 32'(done1), 32'(w == 1));
    check("done_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("done_mem_we", 32'(mem_write_enable), 32'd0);
    check("done_mem_addr", 32'(mem_addr), 32'(t_a));
    if (w == 1) exp_rd1 = t_exp; else exp_rd0 = t_exp;
    @(posedge clk); #1;
  endtask

  task automatic reset_in_issue();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    mode0 = 1'b0; mode1 = 1'b0; addr0 = 5'd2; addr1 = 5'd4;
    @(negedge clk);
    check("rst_pre_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    ref_last = 1 - ref_last;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("rst_issue_gnt", 32'({gnt0, gnt1}), ref_last == 0 ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_last = 1;
    exp_rd0 = '0;
    exp_rd1 = '0;
    @(negedge clk);
    check("rst_abort_done", 32'({done0, done1}), 32'd0);
    check("rst_abort_busy", 32'(busy), 32'd0);
    check("rst_abort_rdata0", rdata0, 32'd0);
    check("rst_abort_rdata1", rdata1, 32'd0);
    check("rst_abort_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_cells[i] = $urandom;
      ref_mem[i]   = mem_cells[i];
    end
    ref_last = 1;
    exp_rd0 = '0;
    exp_rd1 = '0;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; mode0 = 0; mode1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 32'({gnt0, gnt1, done0, done1, busy, mem_write_enable, mem_mode}), 32'd0);
    check("reset_addr", 32'(mem_addr), 32'd0);
    check("reset_datain", mem_datain, 32'd0);
    check("reset_rdata0", rdata0, 32'd0);
    check("reset_rdata1", rdata1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_slot(1, 0, 1, 0, 0, 0, 5'd3, 5'd0, 32'hA5A5A5A5, 32'h0, 0);
    do_slot(0, 1, 0, 1, 0, 1, 5'd0, 5'd3, 32'h0, 32'h12345678, 0);
    do_slot(1, 1, 0, 0, 0, 0, 5'd3, 5'd9, 32'h0, 32'h0, 1);
    check("swap_old_value", exp_rd1, 32'hA5A5A5A5);

    for (int i = 0; i < 6; i++)
      do_slot(1, 1, 1, 1, 0, 0, 5'd5, 5'd6, 32'h100 + i, 32'h200 + i, 0);

    reset_in_issue();
    do_slot(1, 1, 0, 0, 0, 0, 5'd5, 5'd6, 32'h0, 32'h0, 0);

    for (int i = 0; i < 60; i++)
      do_slot(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), $urandom, $urandom, 1);

    do_slot(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 0);
    do_slot(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
